// File: rtl/morse_symbol_classifier.sv
// Morse element classifier: times debounced key presses/releases in dot units, emits letter codes and word strobes.
// Define MORSE_MIN_PRESS_EN to reject presses shorter than MIN_PRESS_CYCLES as glitches.
module morse_symbol_classifier #(
    parameter int UNIT_CYCLES      = 5_000_000,
    parameter int DASH_UNITS       = 2,
    parameter int LETTER_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS   = 7,
    parameter int MAX_ELEMS        = 5
`ifdef MORSE_MIN_PRESS_EN
    ,
    parameter int MIN_PRESS_CYCLES = UNIT_CYCLES / 4
`endif
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             db_btn_i,
    output logic                             letter_valid_o,
    output logic [MAX_ELEMS-1:0]             code_o,
    output logic [$clog2(MAX_ELEMS+1)-1:0]   len_o,
    output logic                             letter_err_o,
    output logic                             word_end_o,
    output logic                             busy_o
);
    localparam int PW = $clog2(UNIT_CYCLES);
    localparam int UW = $clog2(WORD_GAP_UNITS + 1);
    localparam int LW = $clog2(MAX_ELEMS + 1);
    localparam logic [PW-1:0] PRESC_TOP   = PW'(UNIT_CYCLES - 1);
    localparam logic [UW-1:0] DASH_U      = UW'(DASH_UNITS);
    localparam logic [UW-1:0] LETTER_LAST = UW'(LETTER_GAP_UNITS - 1);
    localparam logic [UW-1:0] WORD_LAST   = UW'(WORD_GAP_UNITS - 1);
    localparam logic [UW-1:0] WORD_U      = UW'(WORD_GAP_UNITS);
    localparam logic [LW-1:0] MAX_LEN     = LW'(MAX_ELEMS);

    typedef enum logic [1:0] {IDLE, PRESS, GAP, WORD_WAIT} state_t;
    state_t state, state_nxt, press_exit;

    logic                 btn_q, rise, fall, key_edge, tick, glitch;
    logic [PW-1:0]        presc;
    logic [UW-1:0]        unit_cnt;
    logic [MAX_ELEMS-1:0] code_acc;
    logic [LW-1:0]        len_acc;
    logic                 ovf, is_dash, elem_add, emit_letter, emit_word;

    assign rise     = db_btn_i & ~btn_q;
    assign fall     = ~db_btn_i & btn_q;
    assign key_edge = rise | fall;
    assign tick     = (presc == PRESC_TOP);
    assign is_dash  = (unit_cnt >= DASH_U);

`ifdef MORSE_MIN_PRESS_EN
    localparam int CW = $clog2(MIN_PRESS_CYCLES + 2);
    localparam logic [CW-1:0] MIN_LEN = CW'(MIN_PRESS_CYCLES);
    logic [CW-1:0] press_len;
    logic [PW-1:0] gap_presc, gap_presc_nxt;
    logic [UW-1:0] gap_unit, gap_unit_nxt;
    state_t        resume;

    assign glitch     = fall && (state == PRESS) && (press_len < MIN_LEN);
    assign press_exit = glitch ? resume : GAP;

    // Release timer that ignores rises, so a rejected press leaves gap timing untouched.
    always_comb begin
        gap_presc_nxt = gap_presc + 1'b1;
        gap_unit_nxt  = gap_unit;
        if (gap_presc == PRESC_TOP) begin
            gap_presc_nxt = '0;
            if (gap_unit != WORD_U) gap_unit_nxt = gap_unit + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_len <= '0;
            resume    <= IDLE;
            gap_presc <= '0;
            gap_unit  <= '0;
        end else begin
            if (rise) begin
                press_len <= CW'(1);
                resume    <= state;
            end else if (state == PRESS && press_len < MIN_LEN) begin
                press_len <= press_len + 1'b1;
            end
            if (fall && !glitch) begin
                gap_presc <= '0;
                gap_unit  <= '0;
            end else begin
                gap_presc <= gap_presc_nxt;
                gap_unit  <= gap_unit_nxt;
            end
        end
    end
`else
    assign glitch     = 1'b0;
    assign press_exit = GAP;
`endif

    // Edges restart timing and take priority over a coincident tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q    <= 1'b1;
            presc    <= '0;
            unit_cnt <= '0;
        end else begin
            btn_q <= db_btn_i;
`ifdef MORSE_MIN_PRESS_EN
            if (glitch) begin
                presc    <= gap_presc_nxt;
                unit_cnt <= gap_unit_nxt;
            end else
`endif
            if (key_edge) begin
                presc    <= '0;
                unit_cnt <= '0;
            end else if (tick) begin
                presc <= '0;
                if (unit_cnt != WORD_U) unit_cnt <= unit_cnt + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (rise) state_nxt = PRESS;
            PRESS:     if (fall) state_nxt = press_exit;
            GAP:       if (rise) state_nxt = PRESS;
                       else if (tick && unit_cnt == LETTER_LAST) state_nxt = WORD_WAIT;
            WORD_WAIT: if (rise) state_nxt = PRESS;
                       else if (tick && unit_cnt == WORD_LAST) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state != IDLE);
        elem_add    = (state == PRESS) && fall && !glitch;
        emit_letter = (state == GAP) && !rise && tick && (unit_cnt == LETTER_LAST);
        emit_word   = (state == WORD_WAIT) && !rise && tick && (unit_cnt == WORD_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_acc       <= '0;
            len_acc        <= '0;
            ovf            <= 1'b0;
            letter_valid_o <= 1'b0;
            word_end_o     <= 1'b0;
            code_o         <= '0;
            len_o          <= '0;
            letter_err_o   <= 1'b0;
        end else begin
            letter_valid_o <= emit_letter;
            word_end_o     <= emit_word;
            if (emit_letter) begin
                code_o       <= code_acc;
                len_o        <= len_acc;
                letter_err_o <= ovf;
                code_acc     <= '0;
                len_acc      <= '0;
                ovf          <= 1'b0;
            end else if (elem_add) begin
                if (len_acc < MAX_LEN) begin
                    code_acc <= code_acc | (MAX_ELEMS'(is_dash) << len_acc);
                    len_acc  <= len_acc + 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end
        end
    end
endmodule
